// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit that owns
// the HI/LO registers. Multiply is radix-2 shift-add on operand magnitudes;
// divide is restoring shift-subtract. A final FIX cycle restores signs.
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [1:0]       hilo_sel_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;    // |rt|: multiplicand or divisor
  logic [WIDTH-1:0] b_q;    // |rs| shifting out; becomes product low half / quotient
  logic [WIDTH-1:0] acc_q;  // product high half / partial remainder
  logic             is_div_q, neg_q_q, neg_r_q, divz_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic rtype, is_muldiv, is_hilo, start;
  logic rs_neg, rt_neg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign rtype     = (op_i == 6'b000000);
  assign is_muldiv = rtype && (funct_i[5:2] == 4'b0110);
  assign is_hilo   = is_muldiv || (rtype && (funct_i[5:2] == 4'b0100));
  assign stall_o   = valid_i & busy_o & is_hilo;
  assign start     = valid_i & is_muldiv & ~stall_o & (state_q == IDLE);

  // Signed variants (MULT, DIV) have funct[0] = 0
  assign rs_neg = ~funct_i[0] & rs_data_i[WIDTH-1];
  assign rt_neg = ~funct_i[0] & rt_data_i[WIDTH-1];

  // ALU control decode; funct table applies only to R-type
  always_comb begin
    alu_ctrl_o = 4'b1111;
    if (rtype) begin
      case (funct_i)
        6'b100000: alu_ctrl_o = 4'b0000;
        6'b100010: alu_ctrl_o = 4'b0001;
        6'b100100: alu_ctrl_o = 4'b0010;
        6'b100101: alu_ctrl_o = 4'b0011;
        6'b100110: alu_ctrl_o = 4'b0101;
        6'b100111: alu_ctrl_o = 4'b0110;
        6'b000000: alu_ctrl_o = 4'b0111;
        6'b000010: alu_ctrl_o = 4'b1000;
        6'b000011: alu_ctrl_o = 4'b1001;
        6'b101010: alu_ctrl_o = 4'b1100;
        default:   alu_ctrl_o = 4'b1111;
      endcase
    end else begin
      case (op_i)
        6'b001000, 6'b100011, 6'b101011: alu_ctrl_o = 4'b0000;
        6'b000100: alu_ctrl_o = 4'b0001;
        6'b001100: alu_ctrl_o = 4'b0010;
        6'b001101: alu_ctrl_o = 4'b0011;
        6'b001110: alu_ctrl_o = 4'b0101;
        6'b001010: alu_ctrl_o = 4'b1100;
        default:   alu_ctrl_o = 4'b1111;
      endcase
    end
  end

  // Writeback source select for MFHI/MFLO
  always_comb begin
    hilo_sel_o = 2'b00;
    if (rtype && funct_i == F_MFHI) hilo_sel_o = 2'b01;
    if (rtype && funct_i == F_MFLO) hilo_sel_o = 2'b10;
  end

  // One iteration step and the final sign correction
  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : '0)};
    div_sh   = {acc_q, b_q[WIDTH-1]};
    // Top bit set means the trial subtraction borrowed
    div_diff = div_sh - {1'b0, a_q};
    prod     = {acc_q, b_q};
    prod_fix = neg_q_q ? -prod : prod;
    quo_fix  = divz_q ? '1 : (neg_q_q ? -b_q : b_q);
    // Remainder follows the dividend; for divide-by-zero this rebuilds rs
    rem_fix  = neg_r_q ? -acc_q : acc_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= rt_neg ? -rt_data_i : rt_data_i;
            b_q      <= rs_neg ? -rs_data_i : rs_data_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            is_div_q <= funct_i[1];
            neg_q_q  <= rs_neg ^ rt_neg;
            neg_r_q  <= rs_neg;
            divz_q   <= (rt_data_i == '0);
          end else if (valid_i && rtype && funct_i == F_MTHI) begin
            hi_q <= rs_data_i;
          end else if (valid_i && rtype && funct_i == F_MTLO) begin
            lo_q <= rs_data_i;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_q <= div_diff[WIDTH-1:0];
              b_q   <= {b_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= div_sh[WIDTH-1:0];
              b_q   <= {b_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            b_q   <= {mul_sum[0], b_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench: decode vector table, mul/div result table fed through a
// scoreboard queue, then hand sequences for hazards and mid-operation reset.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [5:0]   op = '0, funct = '0;
  logic [W-1:0] rs = '0, rt = '0;
  logic [3:0]   alu_ctrl;
  logic [1:0]   hilo_sel;
  logic         stall, busy, done;
  logic [W-1:0] hi, lo;

  alu_ctrl_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .op_i(op), .funct_i(funct),
    .rs_data_i(rs), .rt_data_i(rt), .alu_ctrl_o(alu_ctrl), .hilo_sel_o(hilo_sel),
    .stall_o(stall), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_done = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("sb_hi", hi, mon_e[2*W-1:W]);
        chk("sb_lo", lo, mon_e[W-1:0]);
      end
    end
  end

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] alu;
    logic [1:0] sel;
  } dec_vec_t;

  typedef struct {
    string      name;
    logic [5:0] funct;
    logic [W-1:0] a, b, hi, lo;
  } md_vec_t;

  dec_vec_t dv[14];
  md_vec_t  mv[10];

  // Issue one mul/div, push its expected result, check busy length and single done
  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int bc, to, d0;
    d0 = n_done;
    @(negedge clk);
    valid = 1'b1; op = 6'b0; funct = f; rs = a; rt = b;
    exp_q.push_back({eh, el});
    @(negedge clk);
    valid = 1'b0;
    bc = 0; to = 0;
    while (busy && to < 100) begin bc++; to++; @(negedge clk); end
    chk({name, "_busy_cycles"}, bc, 33);
    @(negedge clk);
    chk({name, "_done_pulses"}, n_done - d0, 1);
  endtask

  initial begin
    int bad, sc, to, d0;

    dv[0]  = '{6'b001000, 6'b000000, 4'b0000, 2'b00};
    dv[1]  = '{6'b100011, 6'b111111, 4'b0000, 2'b00};
    dv[2]  = '{6'b000000, 6'b100111, 4'b0110, 2'b00};
    dv[3]  = '{6'b000000, 6'b000011, 4'b1001, 2'b00};
    dv[4]  = '{6'b001010, 6'b000000, 4'b1100, 2'b00};
    dv[5]  = '{6'b111111, 6'b100000, 4'b1111, 2'b00};
    dv[6]  = '{6'b000000, 6'b011000, 4'b1111, 2'b00};
    dv[7]  = '{6'b000000, 6'b010000, 4'b1111, 2'b01};
    dv[8]  = '{6'b000000, 6'b010010, 4'b1111, 2'b10};
    dv[9]  = '{6'b000000, 6'b000000, 4'b0111, 2'b00};
    dv[10] = '{6'b000100, 6'b000000, 4'b0001, 2'b00};
    dv[11] = '{6'b001101, 6'b000000, 4'b0011, 2'b00};
    dv[12] = '{6'b000000, 6'b101010, 4'b1100, 2'b00};
    dv[13] = '{6'b001110, 6'b100111, 4'b0101, 2'b00};

    mv[0] = '{"mult",      6'b011000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    mv[1] = '{"multu",     6'b011001, 32'd7,        32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB};
    mv[2] = '{"divu",      6'b011011, 32'd100,      32'd7,        32'd2,        32'd14};
    mv[3] = '{"div_neg",   6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[4] = '{"div_ovf",   6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    mv[5] = '{"divu_z",    6'b011011, 32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF};
    mv[6] = '{"div_z",     6'b011010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    mv[7] = '{"div_negd",  6'b011010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    mv[8] = '{"mult_min",  6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    mv[9] = '{"multu_max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    // Decode sweep; valid only pulses between edges so nothing starts
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      valid = 1'b1; op = dv[i].op; funct = dv[i].funct;
      #1;
      chk($sformatf("dec_alu_%0d", i), alu_ctrl, dv[i].alu);
      chk($sformatf("dec_sel_%0d", i), hilo_sel, dv[i].sel);
      valid = 1'b0;
    end

    // valid low never starts or writes
    @(negedge clk);
    op = 6'b0; funct = 6'b011000; rs = 32'd5; rt = 32'd5;
    @(negedge clk);
    chk("novalid_busy", busy, 0);
    funct = 6'b010001;
    @(negedge clk);
    chk("novalid_mthi", hi, 0);

    // Mul/div result table
    for (int i = 0; i < 10; i++)
      run_op(mv[i].name, mv[i].funct, mv[i].a, mv[i].b, mv[i].hi, mv[i].lo);

    // MULT then MFHI: stalls until the done cycle, which sees the new HI
    @(negedge clk);
    valid = 1'b1; op = 6'b0; funct = 6'b011000; rs = 32'd9; rt = 32'hFFFFFFFF;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF7});
    @(negedge clk);
    funct = 6'b010000;
    bad = 0; sc = 0; to = 0;
    while (!done && to < 100) begin
      #1;
      if (!(stall === 1'b1 && hilo_sel === 2'b01)) bad++;
      sc++; to++;
      @(negedge clk);
    end
    #1;
    chk("mfhi_stall_bad", bad, 0);
    chk("mfhi_stall_cycles", sc, 33);
    chk("mfhi_done_stall", stall, 0);
    chk("mfhi_done_hi", hi, 32'hFFFFFFFF);
    valid = 1'b0;

    // ADD proceeds while busy; a second DIV waits then starts after done
    @(negedge clk);
    valid = 1'b1; op = 6'b0; funct = 6'b011011; rs = 32'd100; rt = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    @(negedge clk);
    funct = 6'b100000;
    #1;
    chk("add_busy_stall", stall, 0);
    chk("add_busy_alu", alu_ctrl, 4'b0000);
    @(negedge clk);
    funct = 6'b011010; rs = 32'hFFFFFFF9; rt = 32'd2;
    bad = 0; to = 0;
    while (!done && to < 100) begin
      #1;
      if (stall !== 1'b1) bad++;
      to++;
      @(negedge clk);
    end
    #1;
    chk("div2_stall_bad", bad, 0);
    chk("div2_done_stall", stall, 0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    @(negedge clk);
    chk("div2_started", busy, 1);
    valid = 1'b0;
    d0 = n_done; to = 0;
    while (busy && to < 100) begin to++; @(negedge clk); end
    @(negedge clk);
    chk("div2_done_pulses", n_done - d0, 1);

    // Reset during RUN aborts the multiply
    @(negedge clk);
    valid = 1'b1; op = 6'b0; funct = 6'b011000; rs = 32'd7; rt = 32'd3;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = n_done;
    repeat (40) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_lo_hold", lo, 0);

    // MTLO / MTHI take one edge and never raise busy or done
    valid = 1'b1; op = 6'b0; funct = 6'b010011; rs = 32'hA5;
    @(posedge clk);
    #1;
    chk("mtlo_lo", lo, 32'hA5);
    chk("mtlo_busy", busy, 0);
    funct = 6'b010001; rs = 32'h5A;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("mthi_hi", hi, 32'h5A);
    chk("mthi_lo_kept", lo, 32'hA5);
    @(negedge clk);
    chk("mt_no_done", done, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
